sonic_echo_emulator: RTL
========================

// Module: sonic_echo_emulator
// PURPOSE
//  Responder end of the HC-SR04 trig/echo link: accepts the Trig pulse that sonic_top drives and
//  returns an Echo pulse whose width encodes a programmed distance (58 us per cm).
//  Used as the on-board/simulation stand-in for the ultrasonic sensor, so sonic_top and the
//  petting/expecting thresholds can be exercised without hardware.
// PARAMETERS
//  CLK_HZ       100_000_000  system clock frequency
//  TRIG_MIN_CYC 1000         minimum valid Trig high width (10 us)
//  BURST_CYC    20000        Trig-fall to Echo-rise delay (200 us, 8x40 kHz burst)
//  CYC_PER_CM   5800         Echo-high cycles per cm (58 us)
//  MAX_CM       400          largest valid distance; larger or 0 -> no-target timeout
//  TIMEOUT_CYC  3_800_000    Echo-high width for no-target (38 ms)
//  HOLDOFF_CYC  1_000_000    dead time after Echo fall before re-arming (10 ms)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-low reset
//  trig         in   1   Trig from sonic_top (asynchronous; synchronised internally)
//  distance_cm  in   9   target distance, sampled on the accepted Trig fall
//  echo         out  1   Echo pulse back to sonic_top
//  busy         out  1   high in any state other than IDLE
//  trig_err     out  1   one-cycle strobe: Trig pulse shorter than TRIG_MIN_CYC
// BEHAVIOUR
//  - Reset (rst=0, any time, incl. mid-Echo): state=IDLE, echo=0, busy=0, trig_err=0, counters=0,
//    taking effect asynchronously; no Echo completes after reset releases.
//  - trig passes a 2-flop synchroniser; all edge detection uses the synchronised value (2-cycle lag).
//  - FSM: IDLE -> TRIG_HI on sync rise; counter counts high cycles, saturating at TRIG_MIN_CYC.
//    TRIG_HI on fall: count >= TRIG_MIN_CYC -> latch distance_cm, compute width, go BURST;
//    else pulse trig_err for 1 cycle, go IDLE. Trig held high indefinitely stays in TRIG_HI.
//  - BURST: exactly BURST_CYC cycles, echo=0 -> ECHO. echo rises on the first ECHO cycle.
//  - ECHO: echo=1 for exactly W cycles, W = latched_cm*CYC_PER_CM when 1<=latched_cm<=MAX_CM,
//    else W = TIMEOUT_CYC. echo is registered (glitch-free). -> HOLDOFF.
//  - HOLDOFF: HOLDOFF_CYC cycles, echo=0 -> IDLE.
//  - Trig edges in BURST/ECHO/HOLDOFF are ignored (no re-trigger, no trig_err); a Trig already
//    high on HOLDOFF exit is not accepted until it falls and rises again.
//  - distance_cm changes after the latch do not affect the pulse in flight.
//  - Arithmetic: width computed once into a 22-bit register (400*5800=2_320_000, 3_800_000 both
//    < 2^22); single shared 22-bit down-counter for all timed states; no wrap possible.
// STRUCTURE
//  - sonic_pkg: state enum {IDLE,TRIG_HI,BURST,ECHO,HOLDOFF}, CNT_W=22, DIST_W=9, the
//    58 us/cm constant shared with sonic_top's distance conversion.
//  - Sub-module sync_2ff (generic 1-bit 2-flop synchroniser, async active-low reset).
//  - Top of this file: FSM + counter + width register only.
// TESTING
//  1. trig high 1000 cyc, distance_cm=10 -> echo rises 20000+2..3 cyc after trig fall, high 58000 cyc.
//  2. trig high 999 cyc -> trig_err high exactly 1 cyc, echo stays 0, busy returns 0.
//  3. distance_cm=0 and =401 -> echo high 3_800_000 cyc each; =400 -> 2_320_000 cyc.
//  4. second trig pulse mid-ECHO and in HOLDOFF -> echo width unchanged, no second echo, no trig_err.
//  5. rst=0 at cycle 30000 of ECHO -> echo=0, busy=0 immediately; after release, no echo until new trig.
//  6. closed loop with sonic_top, distance_cm=5 -> sonic_top distance output matches 5 cm (+-1).

Source files
------------

// File: rtl/sonic_pkg.sv
// Shared types and constants for the ultrasonic trig/echo link.
package sonic_pkg;

  localparam int CNT_W     = 22;  // wide enough for the longest timed state (38 ms)
  localparam int DIST_W    = 9;   // 0..511 cm
  localparam int US_PER_CM = 58;  // round-trip time per cm, also used by sonic_top

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } sonic_state_t;

  // Echo-high width for a distance; out-of-range (0 or > max_cm) reports no target.
  function automatic logic [CNT_W-1:0] echo_width(
    input logic [DIST_W-1:0] cm,
    input int                cyc_per_cm,
    input int                max_cm,
    input int                timeout_cyc
  );
    logic [CNT_W-1:0] w;
    if (cm != '0 && int'(cm) <= max_cm) w = CNT_W'(int'(cm) * cyc_per_cm);
    else                                w = CNT_W'(timeout_cyc);
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/sonic_echo_emulator.sv
// HC-SR04 stand-in: answers a valid Trig pulse with an Echo pulse whose
// width encodes the programmed distance.
module sonic_echo_emulator
  import sonic_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TRIG_MIN_CYC = 1000,
  parameter int BURST_CYC    = 20000,
  parameter int CYC_PER_CM   = US_PER_CM * (CLK_HZ / 1_000_000),
  parameter int MAX_CM       = 400,
  parameter int TIMEOUT_CYC  = 3_800_000,
  parameter int HOLDOFF_CYC  = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [DIST_W-1:0] distance_cm,
  output logic              echo,
  output logic              busy,
  output logic              trig_err
);

  logic             trig_s;
  logic             trig_prev_reg;
  sonic_state_t     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] width_reg, width_next;
  logic             echo_reg, echo_next;
  logic             trig_err_reg, trig_err_next;

  logic trig_rise;
  logic trig_fall;
  logic cnt_last;
  logic long_enough;

  sync_2ff u_trig_sync (
    .clk (clk),
    .rst (rst),
    .d   (trig),
    .q   (trig_s)
  );

  assign trig_rise   = trig_s & ~trig_prev_reg;
  assign trig_fall   = ~trig_s & trig_prev_reg;
  assign cnt_last    = (cnt_reg == CNT_W'(1));
  assign long_enough = (cnt_reg >= CNT_W'(TRIG_MIN_CYC));

  // State, shared counter, latched width and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      width_reg     <= '0;
      trig_prev_reg <= 1'b0;
      echo_reg      <= 1'b0;
      trig_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      width_reg     <= width_next;
      trig_prev_reg <= trig_s;
      echo_reg      <= echo_next;
      trig_err_reg  <= trig_err_next;
    end
  end

  // Next state plus counter/width updates; timed states count down to 1.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    width_next = width_reg;
    case (state_reg)
      IDLE: begin
        // Edge-only acceptance: a Trig still high from HOLDOFF must fall first.
        if (trig_rise) begin
          state_next = TRIG_HI;
          cnt_next   = CNT_W'(1);
        end
      end
      TRIG_HI: begin
        if (trig_fall) begin
          if (long_enough) begin
            state_next = BURST;
            cnt_next   = CNT_W'(BURST_CYC);
            width_next = echo_width(distance_cm, CYC_PER_CM, MAX_CM, TIMEOUT_CYC);
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else if (!long_enough) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      BURST: begin
        if (cnt_last) begin
          state_next = ECHO;
          cnt_next   = width_reg;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ECHO: begin
        if (cnt_last) begin
          state_next = HOLDOFF;
          cnt_next   = CNT_W'(HOLDOFF_CYC);
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_last) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs: echo/trig_err are precomputed from the next state so they leave a flop.
  always_comb begin
    echo_next     = (state_next == ECHO);
    trig_err_next = (state_reg == TRIG_HI) && trig_fall && !long_enough;
    busy          = (state_reg != IDLE);
  end

  assign echo     = echo_reg;
  assign trig_err = trig_err_reg;

endmodule
